// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: mnemonics, opcodes, funct codes.
// Imported by both the instruction encoder and the control unit.
package mips_pkg;

  typedef enum logic [3:0] {
    M_ADD  = 4'd0,
    M_SUB  = 4'd1,
    M_AND  = 4'd2,
    M_OR   = 4'd3,
    M_NOR  = 4'd4,
    M_SLT  = 4'd5,
    M_ADDI = 4'd6,
    M_LW   = 4'd7,
    M_SW   = 4'd8,
    M_BEQ  = 4'd9,
    M_J    = 4'd10
  } mnem_e;

  typedef enum logic {
    S_FILL,
    S_FULL
  } enc_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  function automatic logic [31:0] r_word(
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [4:0] rd,
    input logic [5:0] fn
  );
    return {OP_RTYPE, rs, rt, rd, 5'b00000, fn};
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Source-side handshake plus instruction-memory write port.
// slave is the encoder view, master the producer/memory view.
interface instr_encoder_if #(
  parameter int AW = 6
);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    mnem;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [15:0]   imm;
  logic [25:0]   target;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  modport master (
    output in_valid, mnem, rs, rt, rd, imm, target,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, mnem, rs, rt, rd, imm, target,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_pack.sv
// Combinational mnemonic + fields -> 32-bit MIPS word.
// legal_o drops for unassigned mnemonic codes.
module instr_pack
  import mips_pkg::*;
(
  input  logic [3:0]  mnem_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  always_comb begin
    word_o  = '0;
    legal_o = 1'b1;
    unique case (mnem_i)
      M_ADD:   word_o = r_word(rs_i, rt_i, rd_i, FN_ADD);
      M_SUB:   word_o = r_word(rs_i, rt_i, rd_i, FN_SUB);
      M_AND:   word_o = r_word(rs_i, rt_i, rd_i, FN_AND);
      M_OR:    word_o = r_word(rs_i, rt_i, rd_i, FN_OR);
      M_NOR:   word_o = r_word(rs_i, rt_i, rd_i, FN_NOR);
      M_SLT:   word_o = r_word(rs_i, rt_i, rd_i, FN_SLT);
      M_ADDI:  word_o = {OP_ADDI, rs_i, rt_i, imm_i};
      M_LW:    word_o = {OP_LW, rs_i, rt_i, imm_i};
      M_SW:    word_o = {OP_SW, rs_i, rt_i, imm_i};
      M_BEQ:   word_o = {OP_BEQ, rs_i, rt_i, imm_i};
      M_J:     word_o = {OP_J, target_i};
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded instructions into instruction memory, one word
// per accepted transfer, stopping at DEPTH; sticky illegal flag.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  instr_encoder_if.slave           bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  enc_state_e    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic [31:0] word;
  logic        legal;
  logic        fire;

  instr_pack u_pack (
    .mnem_i   (bus.mnem),
    .rs_i     (bus.rs),
    .rt_i     (bus.rt),
    .rd_i     (bus.rd),
    .imm_i    (bus.imm),
    .target_i (bus.target),
    .word_o   (word),
    .legal_o  (legal)
  );

  assign full         = (state_q == S_FULL);
  assign bus.in_ready = !full;
  assign fire         = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (clear) begin
      state_d = S_FILL;
      ptr_d   = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else if (fire) begin
      if (legal) begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = word;
        cnt_d   = cnt_q + 1'b1;
        // Pointer parks on the last slot rather than wrapping.
        if (cnt_q == LAST) begin
          state_d = S_FULL;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FILL;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign count         = cnt_q;
  assign err           = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder with DEPTH=4.
// Inputs change on the falling edge; outputs sampled 1ns after rising.
module tb_instr_encoder;
  import mips_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [AW:0] count;
  logic        full;
  logic        err;

  int n_chk = 0;
  int n_err = 0;

  instr_encoder_if #(.AW(AW)) bus ();

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus),
    .count (count),
    .full  (full),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] m,
                      input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [15:0] i,
                      input logic [25:0] tg, input logic c);
    @(negedge clk);
    bus.in_valid = v;
    bus.mnem     = m;
    bus.rs       = s;
    bus.rt       = t;
    bus.rd       = d;
    bus.imm      = i;
    bus.target   = tg;
    clear        = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".we"},    32'(bus.mem_we),    32'd0);
    chk({tag, ".addr"},  32'(bus.mem_addr),  32'd0);
    chk({tag, ".wdata"}, bus.mem_wdata,      32'd0);
    chk({tag, ".count"}, 32'(count),         32'd0);
    chk({tag, ".err"},   32'(err),           32'd0);
    chk({tag, ".full"},  32'(full),          32'd0);
    chk({tag, ".rdy"},   32'(bus.in_ready),  32'd1);
  endtask

  logic [3:0]  fill_m [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
  logic [31:0] fill_w [5] = '{32'h00221822, 32'h00221824, 32'h00221825,
                              32'h00221827, 32'h0022182A};

  initial begin
    bus.in_valid = 1'b0;
    bus.mnem     = '0;
    bus.rs       = '0;
    bus.rt       = '0;
    bus.rd       = '0;
    bus.imm      = '0;
    bus.target   = '0;
    #1;
    chk_reset("rst0");
    @(negedge clk);
    rst = 1'b0;

    step(1'b1, M_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
    chk("add.we",    32'(bus.mem_we),   32'd1);
    chk("add.addr",  32'(bus.mem_addr), 32'd0);
    chk("add.wdata", bus.mem_wdata,     32'h00221820);
    chk("add.count", 32'(count),        32'd1);

    step(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b1);
    chk("clr1.count", 32'(count), 32'd0);

    step(1'b1, M_LW, 5'd29, 5'd8, 5'd0, 16'h0004, 26'd0, 1'b0);
    chk("lw.we",    32'(bus.mem_we),   32'd1);
    chk("lw.addr",  32'(bus.mem_addr), 32'd0);
    chk("lw.wdata", bus.mem_wdata,     32'h8FA80004);
    step(1'b1, M_BEQ, 5'd4, 5'd5, 5'd0, 16'hFFFF, 26'd0, 1'b0);
    chk("beq.we",    32'(bus.mem_we),   32'd1);
    chk("beq.addr",  32'(bus.mem_addr), 32'd1);
    chk("beq.wdata", bus.mem_wdata,     32'h1085FFFF);
    step(1'b1, M_J, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0000010, 1'b0);
    chk("j.addr",  32'(bus.mem_addr), 32'd2);
    chk("j.wdata", bus.mem_wdata,     32'h08000010);
    chk("j.count", 32'(count),        32'd3);
    idle();
    chk("hold.we",    32'(bus.mem_we), 32'd0);
    chk("hold.wdata", bus.mem_wdata,   32'h08000010);

    step(1'b1, 4'd13, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
    chk("ill.we",    32'(bus.mem_we), 32'd0);
    chk("ill.count", 32'(count),      32'd3);
    chk("ill.err",   32'(err),        32'd1);
    step(1'b1, M_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
    chk("ill2.we",    32'(bus.mem_we),   32'd1);
    chk("ill2.addr",  32'(bus.mem_addr), 32'd3);
    chk("ill2.err",   32'(err),          32'd1);
    chk("ill2.full",  32'(full),         32'd1);
    chk("ill2.rdy",   32'(bus.in_ready), 32'd0);
    step(1'b1, M_ADD, 5'd7, 5'd7, 5'd7, 16'd0, 26'd0, 1'b0);
    chk("ovf.we",    32'(bus.mem_we), 32'd0);
    chk("ovf.count", 32'(count),      32'd4);
    chk("ovf.wdata", bus.mem_wdata,   32'h00221820);

    step(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b1);
    chk("clr2.count", 32'(count),        32'd0);
    chk("clr2.full",  32'(full),         32'd0);
    chk("clr2.rdy",   32'(bus.in_ready), 32'd1);
    chk("clr2.err",   32'(err),          32'd0);

    for (int k = 0; k < 5; k++) begin
      step(1'b1, fill_m[k], 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
      chk($sformatf("fill%0d.we", k), 32'(bus.mem_we),
          (k < 4) ? 32'd1 : 32'd0);
      chk($sformatf("fill%0d.addr", k), 32'(bus.mem_addr),
          (k < 4) ? 32'(k) : 32'd3);
      chk($sformatf("fill%0d.wdata", k), bus.mem_wdata,
          (k < 4) ? fill_w[k] : fill_w[3]);
    end
    chk("fill.full", 32'(full),  32'd1);
    chk("fill.cnt",  32'(count), 32'd4);

    step(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b1);
    step(1'b1, M_ADDI, 5'd3, 5'd4, 5'd0, 16'h8001, 26'd0, 1'b0);
    chk("addi.wdata", bus.mem_wdata, 32'h20648001);
    step(1'b1, M_SW, 5'd2, 5'd7, 5'd0, 16'h0010, 26'd0, 1'b0);
    chk("sw.addr",  32'(bus.mem_addr), 32'd1);
    chk("sw.wdata", bus.mem_wdata,     32'hAC470010);
    step(1'b1, M_SUB, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1);
    chk("clrsub.we",    32'(bus.mem_we), 32'd0);
    chk("clrsub.count", 32'(count),      32'd0);

    step(1'b1, M_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
    chk("pre.we", 32'(bus.mem_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("rst1");
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
